// File: rtl/uart_tx_frame.sv
// Framed serial transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// A one-entry holding register lets the next byte queue up so frames go out back-to-back.
module uart_tx_frame #(
   parameter int CLKS_PER_BIT = 20,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_EN    = 1,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 busy,
   output logic                 frame_done
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);
   localparam logic [3:0] BIT_LAST  = 4'(DATA_BITS - 1);
   localparam logic       STOP_LAST = (STOP_BITS == 2);
   localparam logic       ODD       = (PARITY_ODD != 0);
   localparam logic       PAR_ON    = (PARITY_EN != 0);

   state_t               state_q, state_d;
   logic [7:0]           baud_cnt_q, baud_cnt_d;
   logic [3:0]           bit_cnt_q, bit_cnt_d;
   logic                 stop_cnt_q, stop_cnt_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [DATA_BITS-1:0] hold_q, hold_d;
   logic                 hold_full_q, hold_full_d;
   logic                 parity_q, parity_d;
   logic                 tx_q, tx_d;
   logic                 busy_q, busy_d;
   logic                 frame_done_q, frame_done_d;
   logic                 tx_ready_q, tx_ready_d;
   logic                 bit_end;
   logic                 load;
   logic                 accept;

   assign accept = tx_valid & tx_ready_q;

   // NOTE: every signal assigned in this block gets a default first so no path infers a latch.
   always_comb begin
      state_d      = state_q;
      baud_cnt_d   = baud_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      stop_cnt_d   = stop_cnt_q;
      shreg_d      = shreg_q;
      parity_d     = parity_q;
      frame_done_d = 1'b0;
      load         = 1'b0;
      bit_end      = (baud_cnt_q == BAUD_LAST);

      if (state_q != IDLE) begin
         baud_cnt_d = bit_end ? 8'd0 : baud_cnt_q + 8'd1;
      end

      case (state_q)
         IDLE: begin
            load = hold_full_q;
         end
         START: begin
            if (bit_end) begin
               state_d   = DATA;
               bit_cnt_d = 4'd0;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_cnt_q == BIT_LAST) begin
                  state_d    = PAR_ON ? PARITY : STOP;
                  bit_cnt_d  = 4'd0;
                  stop_cnt_d = 1'b0;
               end else begin
                  shreg_d   = shreg_q >> 1;
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_d    = STOP;
               stop_cnt_d = 1'b0;
            end
         end
         STOP: begin
            if (bit_end) begin
               if (stop_cnt_q == STOP_LAST) begin
                  frame_done_d = 1'b1;
                  stop_cnt_d   = 1'b0;
                  state_d      = IDLE;
                  load         = hold_full_q;
               end else begin
                  stop_cnt_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Parity is frozen at load so the host may refill hold during the frame.
      if (load) begin
         state_d    = START;
         shreg_d    = hold_q;
         parity_d   = (^hold_q) ^ ODD;
         baud_cnt_d = 8'd0;
      end

      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shreg_d[0];
         PARITY:  tx_d = parity_d;
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_d != IDLE);

      hold_d      = accept ? tx_data : hold_q;
      hold_full_d = accept ? 1'b1 : (load ? 1'b0 : hold_full_q);
      tx_ready_d  = ~hold_full_d;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         baud_cnt_q   <= 8'd0;
         bit_cnt_q    <= 4'd0;
         stop_cnt_q   <= 1'b0;
         shreg_q      <= '0;
         hold_q       <= '0;
         hold_full_q  <= 1'b0;
         parity_q     <= 1'b0;
         tx_q         <= 1'b1;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         tx_ready_q   <= 1'b1;
      end else begin
         state_q      <= state_d;
         baud_cnt_q   <= baud_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         stop_cnt_q   <= stop_cnt_d;
         shreg_q      <= shreg_d;
         hold_q       <= hold_d;
         hold_full_q  <= hold_full_d;
         parity_q     <= parity_d;
         tx_q         <= tx_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         tx_ready_q   <= tx_ready_d;
      end
   end

   assign tx         = tx_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign tx_ready   = tx_ready_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: four parameterisations share one clock and reset;
// sel picks which instance the stimulus and the line recorder talk to.
module tb_uart_tx_frame;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tb_valid = 1'b0;
   logic [8:0] tb_data = '0;
   int         sel = 0;

   logic rdy0, tx0, busy0, done0;
   logic rdy1, tx1, busy1, done1;
   logic rdy2, tx2, busy2, done2;
   logic rdy3, tx3, busy3, done3;
   logic obs_tx, obs_busy, obs_done, obs_ready;
   logic val0, val1, val2, val3;

   int tests  = 0;
   int errors = 0;

   logic line_tx   [0:511];
   logic line_done [0:511];
   logic line_busy [0:511];
   logic line_rdy  [0:511];

   always #5 clk = ~clk;

   assign val0 = tb_valid && (sel == 0);
   assign val1 = tb_valid && (sel == 1);
   assign val2 = tb_valid && (sel == 2);
   assign val3 = tb_valid && (sel == 3);

   // defaults: 20 clk/bit, 8 data bits, even parity, 1 stop
   uart_tx_frame u0 (.clk(clk), .rst(rst), .tx_data(tb_data[7:0]), .tx_valid(val0),
                     .tx_ready(rdy0), .tx(tx0), .busy(busy0), .frame_done(done0));
   uart_tx_frame #(.PARITY_ODD(1)) u1 (.clk(clk), .rst(rst), .tx_data(tb_data[7:0]), .tx_valid(val1),
                     .tx_ready(rdy1), .tx(tx1), .busy(busy1), .frame_done(done1));
   uart_tx_frame #(.PARITY_EN(0)) u2 (.clk(clk), .rst(rst), .tx_data(tb_data[7:0]), .tx_valid(val2),
                     .tx_ready(rdy2), .tx(tx2), .busy(busy2), .frame_done(done2));
   uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(9), .STOP_BITS(2)) u3 (.clk(clk), .rst(rst),
                     .tx_data(tb_data), .tx_valid(val3),
                     .tx_ready(rdy3), .tx(tx3), .busy(busy3), .frame_done(done3));

   always_comb begin
      obs_tx = tx0; obs_busy = busy0; obs_done = done0; obs_ready = rdy0;
      case (sel)
         1: begin obs_tx = tx1; obs_busy = busy1; obs_done = done1; obs_ready = rdy1; end
         2: begin obs_tx = tx2; obs_busy = busy2; obs_done = done2; obs_ready = rdy2; end
         3: begin obs_tx = tx3; obs_busy = busy3; obs_done = done3; obs_ready = rdy3; end
         default: ;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [8:0] v);
      check("ready_before_send", {31'd0, obs_ready}, 32'd1);
      tb_valid = 1'b1;
      tb_data  = v;
      step();
      tb_valid = 1'b0;
   endtask

   task automatic wait_fall(output int waited);
      waited = 0;
      while (obs_tx !== 1'b0 && waited < 50) begin
         step();
         waited++;
      end
      check("start_bit_seen", {31'd0, obs_tx}, 32'd0);
   endtask

   // Record n+1 samples starting at the current one; optionally offer a byte after sample inj_at.
   task automatic capture(input int n, input int inj_at, input logic [8:0] inj_data);
      for (int i = 0; i <= n; i++) begin
         line_tx[i]   = obs_tx;
         line_done[i] = obs_done;
         line_busy[i] = obs_busy;
         line_rdy[i]  = obs_ready;
         if (i == inj_at) begin
            tb_valid = 1'b1;
            tb_data  = inj_data;
         end else begin
            tb_valid = 1'b0;
         end
         if (i < n) step();
      end
      tb_valid = 1'b0;
   endtask

   function automatic logic [8:0] decode(input int base, input int clks, input int nbits);
      logic [8:0] v = '0;
      for (int k = 0; k < nbits; k++) v[k] = line_tx[base + clks * (k + 1) + clks / 2];
      return v;
   endfunction

   function automatic int first_done(input int from, input int to);
      for (int i = from; i <= to; i++) if (line_done[i] === 1'b1) return i;
      return -1;
   endfunction

   function automatic int count_ones_tx(input int from, input int to);
      int c = 0;
      for (int i = from; i <= to; i++) if (line_tx[i] === 1'b1) c++;
      return c;
   endfunction

   initial begin
      int w;
      int lows;
      int dones;

      // reset and idle line
      repeat (3) step();
      rst = 1'b0;
      check("rst_tx", {31'd0, tx0}, 32'd1);
      check("rst_busy", {31'd0, busy0}, 32'd0);
      check("rst_ready", {31'd0, rdy0}, 32'd1);
      lows = 0; dones = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (tx0 !== 1'b1 || busy0 !== 1'b0 || rdy0 !== 1'b1) lows++;
         if (done0 !== 1'b0) dones++;
      end
      check("idle_line_steady", lows, 0);
      check("idle_no_done", dones, 0);

      // defaults, 0xA5
      sel = 0;
      send(9'h0A5);
      wait_fall(w);
      check("latency_edges", w, 1);
      capture(240, -1, 9'h000);
      check("a5_start_len", 20 - count_ones_tx(0, 19), 20);
      check("a5_data", {23'd0, decode(0, 20, 8)}, 32'h0A5);
      check("a5_bit1_len", count_ones_tx(20, 39), 20);
      check("a5_parity", {31'd0, line_tx[190]}, 32'd0);
      check("a5_stop", {31'd0, line_tx[210]}, 32'd1);
      check("a5_done_at", first_done(0, 240), 220);
      check("a5_busy_on", {31'd0, line_busy[0]}, 32'd1);
      check("a5_busy_off", {31'd0, line_busy[220]}, 32'd0);
      check("a5_done_pulse", {31'd0, line_done[221]}, 32'd0);
      check("a5_ready_after_drain", {31'd0, line_rdy[5]}, 32'd1);

      // back-to-back: 0x55 then 0x0F offered during DATA
      send(9'h055);
      wait_fall(w);
      capture(460, 40, 9'h00F);
      check("b2b_first_data", {23'd0, decode(0, 20, 8)}, 32'h055);
      check("b2b_done1", first_done(0, 460), 220);
      check("b2b_done2", first_done(221, 460), 440);
      check("b2b_stop_before", {31'd0, line_tx[219]}, 32'd1);
      check("b2b_no_gap", {31'd0, line_tx[220]}, 32'd0);
      check("b2b_busy_held", {31'd0, line_busy[220]}, 32'd1);
      check("b2b_second_data", {23'd0, decode(220, 20, 8)}, 32'h00F);
      check("b2b_ready_low", {31'd0, line_rdy[41]}, 32'd0);
      lows = 0;
      for (int i = 41; i < 220; i++) if (line_rdy[i] === 1'b1) lows++;
      check("b2b_ready_held_low", lows, 0);
      check("b2b_ready_after_drain", {31'd0, line_rdy[221]}, 32'd1);
      check("b2b_busy_end", {31'd0, line_busy[440]}, 32'd0);

      // parity variants
      sel = 1;
      send(9'h000);
      wait_fall(w);
      capture(230, -1, 9'h000);
      check("odd_00_parity", {31'd0, line_tx[190]}, 32'd1);
      check("odd_00_data", {23'd0, decode(0, 20, 8)}, 32'h000);
      sel = 0;
      send(9'h007);
      wait_fall(w);
      capture(230, -1, 9'h000);
      check("even_07_parity", {31'd0, line_tx[190]}, 32'd1);
      sel = 2;
      send(9'h03C);
      wait_fall(w);
      capture(230, -1, 9'h000);
      check("nopar_data", {23'd0, decode(0, 20, 8)}, 32'h03C);
      check("nopar_stop", {31'd0, line_tx[190]}, 32'd1);
      check("nopar_done_at", first_done(0, 230), 200);

      // 9 data bits, 2 stop bits, 4 clk/bit
      sel = 3;
      send(9'h1FF);
      wait_fall(w);
      capture(60, -1, 9'h000);
      check("w9_start_len", 4 - count_ones_tx(0, 3), 4);
      check("w9_data", {23'd0, decode(0, 4, 9)}, 32'h1FF);
      check("w9_parity", {31'd0, line_tx[42]}, 32'd1);
      check("w9_stop_len", count_ones_tx(44, 51), 8);
      check("w9_done_at", first_done(0, 60), 52);

      // reset mid-frame with a byte pending
      sel = 0;
      send(9'h05A);
      wait_fall(w);
      capture(98, 20, 9'h033);
      check("pend_ready_low", {31'd0, rdy0}, 32'd0);
      step();
      rst = 1'b1;
      tb_valid = 1'b1;
      tb_data = 9'h0AA;
      step();
      rst = 1'b0;
      tb_valid = 1'b0;
      check("mid_rst_tx", {31'd0, tx0}, 32'd1);
      check("mid_rst_busy", {31'd0, busy0}, 32'd0);
      check("mid_rst_ready", {31'd0, rdy0}, 32'd1);
      lows = 0; dones = 0;
      for (int i = 0; i < 300; i++) begin
         step();
         if (tx0 !== 1'b1) lows++;
         if (done0 !== 1'b0) dones++;
      end
      check("post_rst_no_start", lows, 0);
      check("post_rst_no_done", dones, 0);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
